// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the exhaustive two-input gate tester.
// Truth tables are indexed by the stimulus vector {a,b}.
package gate_tester_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   localparam logic [2:0] ERR_MAX = 3'd4;

   // Saturating increment keeps the mismatch count inside 0..4.
   function automatic logic [2:0] sat_inc_err(input logic [2:0] v);
      logic [2:0] r;
      if (v >= ERR_MAX) begin
         r = ERR_MAX;
      end else begin
         r = v + 3'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/NAND_data_flow.sv
// Reference two-input NAND, usable as the gate under test.
module NAND_data_flow (
   input  logic A,
   input  logic B,
   output logic Y
);

   assign Y = ~(A & B);

endmodule

// File: rtl/gate_tester.sv
// Drives all four {a,b} vectors into a two-input gate, holds each for
// SETTLE_CYCLES+1 cycles, and compares the sampled Y against TRUTH.
module gate_tester
   import gate_tester_pkg::*;
#(
   parameter logic [3:0]  TRUTH         = TT_NAND,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y_i,
   output logic       a_o,
   output logic       b_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_mask
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

   state_e     state_q, state_d;
   logic [1:0] idx_q,   idx_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [1:0] ab_q,    ab_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;
   logic       pass_q,  pass_d;
   logic [2:0] err_q,   err_d;
   logic [3:0] mask_q,  mask_d;
   logic       mismatch_s;

   // State and result registers; reset discards any partial run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         ab_q    <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 3'd0;
         mask_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ab_q    <= ab_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state, stimulus sequencing and result accumulation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      ab_d       = ab_q;
      pass_d     = pass_q;
      err_d      = err_q;
      mask_d     = mask_q;
      mismatch_s = (y_i != TRUTH[idx_q]);

      case (state_q)
         IDLE: begin
            ab_d = 2'd0;
            if (start) begin
               state_d = HOLD;
               idx_d   = 2'd0;
               cnt_d   = SETTLE_LD;
               err_d   = 3'd0;
               mask_d  = 4'd0;
               pass_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (mismatch_s) begin
                  mask_d[idx_q] = 1'b1;
                  err_d         = sat_inc_err(err_q);
               end else begin
                  err_d = err_q;
               end
               // Last vector sampled: publish the verdict as DONE is entered.
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
                  ab_d  = idx_q + 2'd1;
                  cnt_d = SETTLE_LD;
               end else begin
                  state_d = DONE;
                  ab_d    = 2'd0;
                  pass_d  = (err_d == 3'd0);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = 4'd0;
            ab_d    = 2'd0;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign a_o       = ab_q[1];
   assign b_o       = ab_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: good/faulty gates, latency, vector order,
// mid-run reset and back-to-back runs.
module tb_gate_tester;
   import gate_tester_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start0, start1, start2;
   logic [1:0] mode0;
   logic       a0, b0, busy0, done0, pass0, y0, nand_y;
   logic [2:0] err0;
   logic [3:0] mask0;
   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [3:0] mask1;
   logic       a2, b2, busy2, done2, pass2, y2;
   logic [2:0] err2;
   logic [3:0] mask2;

   int checks = 0;
   int errors = 0;

   NAND_data_flow u_nand (.A(a0), .B(b0), .Y(nand_y));

   // Mode 0: real NAND, 1: stuck-at-1, 2: stuck-at-0, 3: AND gate.
   always_comb begin
      case (mode0)
         2'd0:    y0 = nand_y;
         2'd1:    y0 = 1'b1;
         2'd2:    y0 = 1'b0;
         default: y0 = a0 & b0;
      endcase
   end

   assign y2 = a2 & b2;

   gate_tester #(.TRUTH(TT_NAND), .SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .y_i(y0), .a_o(a0), .b_o(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0));

   gate_tester #(.TRUTH(TT_NAND), .SETTLE_CYCLES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .y_i(1'b0), .a_o(a1), .b_o(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1));

   gate_tester #(.TRUTH(TT_AND), .SETTLE_CYCLES(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .y_i(y2), .a_o(a2), .b_o(b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_mask(mask2));

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_done(input int sel);
      logic r;
      case (sel)
         0:       r = done0;
         1:       r = done1;
         default: r = done2;
      endcase
      return r;
   endfunction

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       start0 = v;
         1:       start1 = v;
         default: start2 = v;
      endcase
   endtask

   // Called at a negedge; lat counts negedges after the start edge
   // (the 9th one follows edge start+8, so done is seen by edge start+9).
   task automatic do_run(input int sel, input int budget, output int lat);
      int  n;
      logic found;
      set_start(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(sel, 1'b0);
      n     = 1;
      found = 1'b0;
      lat   = -1;
      while (!found && n <= budget) begin
         if (get_done(sel)) begin
            found = 1'b1;
            lat   = n;
         end else begin
            @(negedge clk);
            n++;
         end
      end
   endtask

   initial begin
      int   lat;
      int   dcount;
      logic found;

      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      mode0  = 2'd0;
      repeat (2) @(negedge clk);

      check("rst_ab",   8'({a0, b0}), 8'd0);
      check("rst_busy", 8'(busy0),    8'd0);
      check("rst_done", 8'(done0),    8'd0);
      check("rst_pass", 8'(pass0),    8'd0);
      check("rst_err",  8'(err0),     8'd0);
      check("rst_mask", 8'(mask0),    8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Good NAND, SETTLE=1: vector order, hold length, latency 9.
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         if (n <= 8) begin
            check($sformatf("ord_ab_%0d", n), 8'({a0, b0}), 8'((n - 1) / 2));
            check($sformatf("ord_done_%0d", n), 8'(done0), 8'd0);
            check($sformatf("ord_busy_%0d", n), 8'(busy0), 8'd1);
         end else begin
            check("good_done_at_9", 8'(done0), 8'd1);
            check("good_pass", 8'(pass0), 8'd1);
            check("good_err",  8'(err0),  8'd0);
            check("good_mask", 8'(mask0), 8'd0);
         end
         @(negedge clk);
      end
      check("post_done", 8'(done0), 8'd0);
      check("post_busy", 8'(busy0), 8'd0);
      check("post_ab",   8'({a0, b0}), 8'd0);
      repeat (3) @(negedge clk);
      check("hold_pass", 8'(pass0), 8'd1);

      // Stuck-at-1 output: only vector 3 disagrees with NAND.
      mode0 = 2'd1;
      do_run(0, 20, lat);
      check("sa1_lat",  8'(lat),   8'd9);
      check("sa1_pass", 8'(pass0), 8'd0);
      check("sa1_err",  8'(err0),  8'd1);
      check("sa1_mask", 8'(mask0), 8'b1000);
      repeat (3) @(negedge clk);
      check("sa1_hold_err", 8'(err0), 8'd1);

      // AND gate checked against NAND table: every vector fails.
      mode0 = 2'd3;
      do_run(0, 20, lat);
      check("andn_pass", 8'(pass0), 8'd0);
      check("andn_err",  8'(err0),  8'd4);
      check("andn_mask", 8'(mask0), 8'b1111);

      // Stuck-at-0, SETTLE=0: latency 5, vectors 0..2 fail.
      do_run(1, 20, lat);
      check("sa0_lat",  8'(lat),   8'd5);
      check("sa0_pass", 8'(pass1), 8'd0);
      check("sa0_err",  8'(err1),  8'd3);
      check("sa0_mask", 8'(mask1), 8'b0111);

      // AND gate against AND table passes.
      do_run(2, 20, lat);
      check("and_lat",  8'(lat),   8'd9);
      check("and_pass", 8'(pass2), 8'd1);
      check("and_err",  8'(err2),  8'd0);
      @(negedge clk);

      // Reset during vector 2 with partial failures recorded.
      mode0  = 2'd3;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      found  = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (!found) begin
            if ({a0, b0} == 2'b10) begin
               found = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
      check("rstmid_reach_v2", 8'(found), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_ab",   8'({a0, b0}), 8'd0);
      check("rstmid_busy", 8'(busy0),    8'd0);
      check("rstmid_err",  8'(err0),     8'd0);
      check("rstmid_mask", 8'(mask0),    8'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done0) dcount++;
      end
      check("rstmid_no_done", 8'(dcount), 8'd0);
      mode0 = 2'd0;
      do_run(0, 20, lat);
      check("rstmid_rerun_lat",  8'(lat),   8'd9);
      check("rstmid_rerun_pass", 8'(pass0), 8'd1);
      @(negedge clk);

      // Mid-run start pulse ignored; held start restarts right after IDLE.
      dcount = 0;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         if (done0 && n <= 9) dcount++;
         if (n == 9)  check("b2b_done_at_9", 8'(done0), 8'd1);
         if (n == 10) check("b2b_busy_gap",  8'(busy0), 8'd0);
         if (n == 11) check("b2b_busy_back", 8'(busy0), 8'd1);
         if (n == 3) start0 = 1'b1;
         if (n == 4) start0 = 1'b0;
         if (n == 6) start0 = 1'b1;
         if (n < 11) @(negedge clk);
      end
      check("b2b_single_done", 8'(dcount), 8'd1);
      start0 = 1'b0;
      found  = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (!found) begin
            @(negedge clk);
            if (done0) found = 1'b1;
         end
      end
      check("b2b_second_done", 8'(found), 8'd1);
      check("b2b_second_pass", 8'(pass0), 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 The block SHALL have parameter TRUTH, default 4'b0111, the expected Y for each input vector, where bit i is the expected Y for {a_o,b_o}=i (default is NAND).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, range 0..15, the extra hold cycles per vector before Y is sampled.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request one exhaustive test run; sampled only in IDLE.
REQ-006 Port y_i, input, 1 bit: output of the gate under test.
REQ-007 Port a_o, output, 1 bit: stimulus A to the gate under test.
REQ-008 Port b_o, output, 1 bit: stimulus B to the gate under test.
REQ-009 Port busy, output, 1 bit: high while a run is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-011 Port pass, output, 1 bit: result of the last completed run, valid from done onward.
REQ-012 Port err_cnt, output, 3 bits: number of mismatching vectors in the last run, 0..4.
REQ-013 Port fail_mask, output, 4 bits: bit i set when vector i mismatched in the last run.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, HOLD and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL cause a move to HOLD with vector index 0, {a_o,b_o}=2'b00, hold counter loaded with SETTLE_CYCLES, err_cnt and fail_mask cleared, and pass cleared.
REQ-016 In HOLD with counter>0, the counter SHALL decrement and a_o/b_o SHALL stay stable.
REQ-017 In HOLD with counter=0, y_i SHALL be sampled at that edge and compared with TRUTH[index]; on mismatch, fail_mask[index] SHALL be set and err_cnt incremented.
REQ-018 At that sampling edge, if index<3, index SHALL increment, {a_o,b_o} SHALL take the new index and the counter SHALL reload; if index=3, the FSM SHALL go to DONE.
REQ-019 Each vector SHALL be held for exactly SETTLE_CYCLES+1 cycles, and the vector order SHALL be 00, 01, 10, 11.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL equal (err_cnt==0), and the next state SHALL be IDLE.
REQ-021 Latency from the start edge to done high SHALL be 4*(SETTLE_CYCLES+1)+1 cycles.
REQ-022 busy SHALL be 1 in HOLD and DONE and 0 in IDLE.
REQ-023 start asserted while not in IDLE SHALL be ignored, with no queuing.
REQ-024 start held high continuously SHALL begin a new run on the cycle after DONE returns to IDLE (back-to-back runs).
REQ-025 In IDLE, a_o and b_o SHALL return to 0.
REQ-026 pass, err_cnt and fail_mask SHALL hold their values until the next accepted start.
REQ-027 With SETTLE_CYCLES=0, each vector SHALL be sampled on the first edge after it is driven.
REQ-028 err_cnt SHALL never exceed 4, and no arithmetic wrap SHALL be possible.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and set a_o, b_o, busy, done, pass, err_cnt, fail_mask, index and counter to 0, regardless of the clock.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse and SHALL discard partial results.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-032 Shared package gate_tester_pkg SHALL hold the state enum (IDLE/HOLD/DONE) and truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110 and TT_XOR=4'b0110.
REQ-033 The block SHALL be a single module with no sub-module; counter, index and comparison are inline.
REQ-034 NAND_data_flow SHALL be instantiable as the gate under test in the bench, with a_o/b_o to A/B and Y to y_i.

Verification
REQ-035 Good NAND, SETTLE_CYCLES=1, start pulse -> done at start+9 cycles, pass=1, err_cnt=0, fail_mask=4'b0000.
REQ-036 y_i tied to 1 with TRUTH=TT_NAND -> pass=0, err_cnt=1, fail_mask=4'b1000.
REQ-037 y_i tied to 0 with TRUTH=TT_NAND, SETTLE_CYCLES=0 -> done at start+5, err_cnt=3, fail_mask=4'b0111.
REQ-038 rst_n pulsed low during vector 2 -> outputs 0 at once, no done pulse; a following start gives a full clean run with pass=1.
REQ-039 start re-pulsed mid-run, then held high -> mid-run pulse ignored, single done; with start held, the second run begins the cycle after IDLE and busy drops for exactly 1 cycle.
REQ-040 AND gate under test with TRUTH=TT_AND -> pass=1; the same gate with TRUTH=TT_NAND -> err_cnt=4, fail_mask=4'b1111.
